// File: rtl/hs_dpath_ce_stream_adapter.sv
// rtl/hs_dpath_ce_stream_adapter.sv - credit-gated CE pipeline to valid/ready stream adapter
module hs_dpath_ce_stream_adapter #(
    parameter type DATA_TYPE = logic,
    parameter int  LATENCY   = 1,
    parameter int  DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       pipe_ce,
    input  logic                       pipe_ce_out,
    input  DATA_TYPE                   pipe_dout,
    output logic                       m_valid,
    input  logic                       m_ready,
    output DATA_TYPE                   m_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       err_overflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    if (LATENCY < 1 || DEPTH < 2) begin : g_param_check
        $error("hs_dpath_ce_stream_adapter: LATENCY must be >= 1 and DEPTH >= 2");
    end

    DATA_TYPE        mem [DEPTH];
    logic [CW-1:0]   credits_q, credits_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            err_q, err_d;

    logic issue, pop, full, wr_en, overflow;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign s_ready      = (credits_q != '0) && !srst;
    assign issue        = s_valid && s_ready;
    assign pipe_ce      = issue;
    assign m_valid      = (occ_q != '0);
    assign pop          = m_valid && m_ready;
    assign full         = (occ_q == CW'(DEPTH));
    // A pop frees its slot on the same edge, so a write while full is fine if a pop coincides.
    assign wr_en        = pipe_ce_out && (!full || pop);
    assign overflow     = pipe_ce_out && full && !pop;
    assign m_data       = mem[rd_ptr_q];
    assign occupancy    = occ_q;
    assign err_overflow = err_q;

    always_comb begin
        credits_d = credits_q;
        occ_d     = occ_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_d     = err_q || overflow;

        if (issue && !pop) begin
            credits_d = credits_q - 1'b1;
        end else if (pop && !issue && credits_q != CW'(DEPTH)) begin
            credits_d = credits_q + 1'b1;
        end

        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (wr_en && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !wr_en) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            credits_q <= CW'(DEPTH);
            occ_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            occ_q     <= occ_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset: entries are only observed once occupancy marks them valid.
    always_ff @(posedge clk) begin
        if (wr_en && !srst) begin
            mem[wr_ptr_q] <= pipe_dout;
        end
    end

endmodule

// File: tb/tb_hs_dpath_ce_stream_adapter.sv
// tb/tb_hs_dpath_ce_stream_adapter.sv - directed bench for hs_dpath_ce_stream_adapter
module tb_hs_dpath_ce_stream_adapter;
    logic clk = 1'b0;
    logic srst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    // a: L=3 D=4, b: L=3 D=8, c: L=1 D=2, d: L=2 D=5
    logic       sv_a, srdy_a, pce_a, pco_a, mv_a, mr_a, err_a;
    logic       sv_b, srdy_b, pce_b, pco_b, mv_b, mr_b, err_b;
    logic       sv_c, srdy_c, pce_c, pco_c, mv_c, mr_c, err_c;
    logic       sv_d, srdy_d, pce_d, pco_d, mv_d, mr_d, err_d;
    logic [7:0] din_a, din_b, din_c, din_d;
    logic [7:0] pdo_a, pdo_b, pdo_c, pdo_d;
    logic [7:0] md_a, md_b, md_c, md_d;
    logic [2:0] occ_a;
    logic [3:0] occ_b;
    logic [1:0] occ_c;
    logic [2:0] occ_d;
    logic       frc_c;
    logic [7:0] frc_d;

    logic       ce_a [3];
    logic [7:0] dd_a [3];
    logic       ce_b [3];
    logic [7:0] dd_b [3];
    logic       ce_c [1];
    logic [7:0] dd_c [1];
    logic       ce_d [2];
    logic [7:0] dd_d [2];

    // Fixed-latency pipeline models; srst flushes their CE chains.
    always_ff @(posedge clk) begin
        ce_a[0] <= pce_a && !srst;
        dd_a[0] <= din_a;
        for (int i = 1; i < 3; i++) begin
            ce_a[i] <= ce_a[i-1] && !srst;
            dd_a[i] <= dd_a[i-1];
        end
        ce_b[0] <= pce_b && !srst;
        dd_b[0] <= din_b;
        for (int i = 1; i < 3; i++) begin
            ce_b[i] <= ce_b[i-1] && !srst;
            dd_b[i] <= dd_b[i-1];
        end
        ce_c[0] <= pce_c && !srst;
        dd_c[0] <= din_c;
        ce_d[0] <= pce_d && !srst;
        dd_d[0] <= din_d;
        ce_d[1] <= ce_d[0] && !srst;
        dd_d[1] <= dd_d[0];
    end

    assign pco_a = ce_a[2];
    assign pdo_a = dd_a[2];
    assign pco_b = ce_b[2];
    assign pdo_b = dd_b[2];
    assign pco_c = ce_c[0] | frc_c;
    assign pdo_c = frc_c ? frc_d : dd_c[0];
    assign pco_d = ce_d[1];
    assign pdo_d = dd_d[1];

    hs_dpath_ce_stream_adapter #(.DATA_TYPE(logic [7:0]), .LATENCY(3), .DEPTH(4)) u_a (
        .clk(clk), .srst(srst), .s_valid(sv_a), .s_ready(srdy_a), .pipe_ce(pce_a),
        .pipe_ce_out(pco_a), .pipe_dout(pdo_a), .m_valid(mv_a), .m_ready(mr_a),
        .m_data(md_a), .occupancy(occ_a), .err_overflow(err_a));
    hs_dpath_ce_stream_adapter #(.DATA_TYPE(logic [7:0]), .LATENCY(3), .DEPTH(8)) u_b (
        .clk(clk), .srst(srst), .s_valid(sv_b), .s_ready(srdy_b), .pipe_ce(pce_b),
        .pipe_ce_out(pco_b), .pipe_dout(pdo_b), .m_valid(mv_b), .m_ready(mr_b),
        .m_data(md_b), .occupancy(occ_b), .err_overflow(err_b));
    hs_dpath_ce_stream_adapter #(.DATA_TYPE(logic [7:0]), .LATENCY(1), .DEPTH(2)) u_c (
        .clk(clk), .srst(srst), .s_valid(sv_c), .s_ready(srdy_c), .pipe_ce(pce_c),
        .pipe_ce_out(pco_c), .pipe_dout(pdo_c), .m_valid(mv_c), .m_ready(mr_c),
        .m_data(md_c), .occupancy(occ_c), .err_overflow(err_c));
    hs_dpath_ce_stream_adapter #(.DATA_TYPE(logic [7:0]), .LATENCY(2), .DEPTH(5)) u_d (
        .clk(clk), .srst(srst), .s_valid(sv_d), .s_ready(srdy_d), .pipe_ce(pce_d),
        .pipe_ce_out(pco_d), .pipe_dout(pdo_d), .m_valid(mv_d), .m_ready(mr_d),
        .m_data(md_d), .occupancy(occ_d), .err_overflow(err_d));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if (pce_a !== 1'b0) $display("FAIL reset_pipe_ce got %0h exp 0", pce_a); else n_pass++;
            n_checks++; if (srdy_a !== 1'b0) $display("FAIL reset_s_ready got %0h exp 0", srdy_a); else n_pass++;
        end
        srst = 1'b0;
        #1;
        n_checks++; if (srdy_a !== 1'b1) $display("FAIL post_reset_s_ready got %0h exp 1", srdy_a); else n_pass++;
        n_checks++; if (mv_a !== 1'b0) $display("FAIL post_reset_m_valid got %0h exp 0", mv_a); else n_pass++;
        n_checks++; if (occ_a !== 3'd0) $display("FAIL post_reset_occupancy got %0d exp 0", occ_a); else n_pass++;
        n_checks++; if (err_a !== 1'b0) $display("FAIL post_reset_err got %0h exp 0", err_a); else n_pass++;
        sv_a = 1'b0;
        step();
    endtask

    task automatic test_streaming;
        mr_b = 1'b1;
        for (int c = 0; c < 15; c++) begin
            sv_b  = (c < 8);
            din_b = 8'(8'h11 + c);
            #1;
            if (c < 8) begin
                n_checks++; if (srdy_b !== 1'b1) $display("FAIL stream_s_ready c=%0d got %0h exp 1", c, srdy_b); else n_pass++;
            end
            n_checks++;
            if (mv_b !== (c >= 4 && c <= 11)) $display("FAIL stream_m_valid c=%0d got %0h exp %0h", c, mv_b, (c >= 4 && c <= 11));
            else n_pass++;
            if (c >= 4 && c <= 11) begin
                n_checks++;
                if (md_b !== 8'(8'h11 + c - 4)) $display("FAIL stream_m_data c=%0d got %0h exp %0h", c, md_b, 8'(8'h11 + c - 4));
                else n_pass++;
            end
            step();
        end
        mr_b = 1'b0;
    endtask

    task automatic test_backpressure;
        int acc  = 0;
        int acc2 = 0;
        mr_b = 1'b0;
        for (int c = 0; c < 14; c++) begin
            sv_b  = 1'b1;
            din_b = 8'(8'h11 + acc);
            #1;
            if (pce_b) acc++;
            step();
        end
        n_checks++; if (acc != 8) $display("FAIL bp_accepts got %0d exp 8", acc); else n_pass++;
        n_checks++; if (occ_b !== 4'd8) $display("FAIL bp_occupancy got %0d exp 8", occ_b); else n_pass++;
        n_checks++; if (srdy_b !== 1'b0) $display("FAIL bp_s_ready got %0h exp 0", srdy_b); else n_pass++;
        n_checks++; if (pce_b !== 1'b0) $display("FAIL bp_pipe_ce got %0h exp 0", pce_b); else n_pass++;
        n_checks++; if (md_b !== 8'h11) $display("FAIL bp_head got %0h exp 11", md_b); else n_pass++;
        mr_b = 1'b1;
        step();
        mr_b  = 1'b0;
        din_b = 8'h19;
        #1;
        n_checks++; if (srdy_b !== 1'b1) $display("FAIL bp_credit_return got %0h exp 1", srdy_b); else n_pass++;
        n_checks++; if (md_b !== 8'h12) $display("FAIL bp_after_pop_head got %0h exp 12", md_b); else n_pass++;
        if (pce_b) acc2++;
        for (int c = 0; c < 6; c++) begin
            step();
            din_b = 8'h1a;
            #1;
            if (pce_b) acc2++;
        end
        n_checks++; if (acc2 != 1) $display("FAIL bp_extra_accepts got %0d exp 1", acc2); else n_pass++;
        n_checks++; if (occ_b !== 4'd8) $display("FAIL bp_refill_occupancy got %0d exp 8", occ_b); else n_pass++;
        sv_b = 1'b0;
        mr_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (mv_b !== 1'b1 || md_b !== 8'(8'h12 + k)) $display("FAIL bp_drain k=%0d got v=%0h d=%0h exp v=1 d=%0h", k, mv_b, md_b, 8'(8'h12 + k));
            else n_pass++;
            step();
        end
        n_checks++; if (mv_b !== 1'b0) $display("FAIL bp_drained_m_valid got %0h exp 0", mv_b); else n_pass++;
        n_checks++; if (err_b !== 1'b0) $display("FAIL bp_err got %0h exp 0", err_b); else n_pass++;
        mr_b = 1'b0;
    endtask

    task automatic test_simultaneous;
        sv_c = 1'b1; din_c = 8'h21; mr_c = 1'b0;
        step();
        sv_c = 1'b0;
        step();
        n_checks++; if (mv_c !== 1'b1 || md_c !== 8'h21) $display("FAIL sim_first got v=%0h d=%0h exp v=1 d=21", mv_c, md_c); else n_pass++;
        sv_c = 1'b1; din_c = 8'h22; mr_c = 1'b1;
        #1;
        n_checks++; if (pce_c !== 1'b1) $display("FAIL sim_issue_pop_pipe_ce got %0h exp 1", pce_c); else n_pass++;
        step();
        mr_c = 1'b0; din_c = 8'h23;
        #1;
        n_checks++; if (srdy_c !== 1'b1) $display("FAIL sim_credit_kept got %0h exp 1", srdy_c); else n_pass++;
        n_checks++; if (occ_c !== 2'd0) $display("FAIL sim_occ_after_pop got %0d exp 0", occ_c); else n_pass++;
        step();
        sv_c = 1'b0;
        #1;
        n_checks++; if (srdy_c !== 1'b0) $display("FAIL sim_credit_exhausted got %0h exp 0", srdy_c); else n_pass++;
        step();
        n_checks++; if (occ_c !== 2'd2) $display("FAIL sim_full got %0d exp 2", occ_c); else n_pass++;
        frc_c = 1'b1; frc_d = 8'h24; mr_c = 1'b1;
        step();
        frc_c = 1'b0;
        n_checks++; if (occ_c !== 2'd2) $display("FAIL sim_write_pop_full_occ got %0d exp 2", occ_c); else n_pass++;
        n_checks++; if (err_c !== 1'b0) $display("FAIL sim_write_pop_full_err got %0h exp 0", err_c); else n_pass++;
        n_checks++; if (md_c !== 8'h23) $display("FAIL sim_head_23 got %0h exp 23", md_c); else n_pass++;
        step();
        n_checks++; if (md_c !== 8'h24) $display("FAIL sim_head_24 got %0h exp 24", md_c); else n_pass++;
        step();
        mr_c = 1'b0;
        n_checks++; if (mv_c !== 1'b0) $display("FAIL sim_empty got %0h exp 0", mv_c); else n_pass++;
    endtask

    task automatic test_wrap;
        int sent = 0;
        int rcv  = 0;
        int cyc  = 0;
        int max_occ = 0;
        while (rcv < 12 && cyc < 400) begin
            mr_d  = 1'($urandom_range(0, 1));
            sv_d  = (sent < 12);
            din_d = 8'(sent);
            #1;
            if (pce_d) sent++;
            if (int'(occ_d) > max_occ) max_occ = int'(occ_d);
            if (mv_d && mr_d) begin
                n_checks++;
                if (md_d !== 8'(rcv)) $display("FAIL wrap_order idx=%0d got %0h exp %0h", rcv, md_d, 8'(rcv));
                else n_pass++;
                rcv++;
            end
            step();
            cyc++;
        end
        sv_d = 1'b0;
        mr_d = 1'b0;
        n_checks++; if (rcv != 12) $display("FAIL wrap_count got %0d exp 12 (cycle budget)", rcv); else n_pass++;
        n_checks++; if (max_occ > 5) $display("FAIL wrap_max_occupancy got %0d exp <=5", max_occ); else n_pass++;
        n_checks++; if (mv_d !== 1'b0 || occ_d !== 3'd0) $display("FAIL wrap_final got v=%0h occ=%0d exp v=0 occ=0", mv_d, occ_d); else n_pass++;
    endtask

    task automatic test_overflow_reset;
        sv_c = 1'b1; din_c = 8'h31;
        step();
        din_c = 8'h32;
        step();
        sv_c = 1'b0;
        step();
        n_checks++; if (occ_c !== 2'd2) $display("FAIL ovf_fill got %0d exp 2", occ_c); else n_pass++;
        frc_c = 1'b1; frc_d = 8'hAA; mr_c = 1'b0;
        step();
        frc_c = 1'b0;
        n_checks++; if (err_c !== 1'b1) $display("FAIL ovf_err got %0h exp 1", err_c); else n_pass++;
        n_checks++; if (occ_c !== 2'd2) $display("FAIL ovf_occ got %0d exp 2", occ_c); else n_pass++;
        n_checks++; if (md_c !== 8'h31) $display("FAIL ovf_head got %0h exp 31", md_c); else n_pass++;
        step();
        n_checks++; if (err_c !== 1'b1) $display("FAIL ovf_sticky got %0h exp 1", err_c); else n_pass++;
        mr_c = 1'b1;
        step();
        n_checks++; if (md_c !== 8'h32) $display("FAIL ovf_second got %0h exp 32", md_c); else n_pass++;
        step();
        mr_c = 1'b0;
        n_checks++; if (mv_c !== 1'b0) $display("FAIL ovf_dropped got v=%0h d=%0h exp v=0", mv_c, md_c); else n_pass++;
        n_checks++; if (err_c !== 1'b1) $display("FAIL ovf_sticky2 got %0h exp 1", err_c); else n_pass++;
        sv_c = 1'b1; din_c = 8'h41;
        step();
        srst = 1'b1;
        #1;
        n_checks++; if (srdy_c !== 1'b0 || pce_c !== 1'b0) $display("FAIL rst_gating got rdy=%0h ce=%0h exp 0/0", srdy_c, pce_c); else n_pass++;
        step();
        srst = 1'b0;
        sv_c = 1'b0;
        #1;
        n_checks++; if (err_c !== 1'b0) $display("FAIL rst_err got %0h exp 0", err_c); else n_pass++;
        n_checks++; if (occ_c !== 2'd0 || mv_c !== 1'b0) $display("FAIL rst_occ got occ=%0d v=%0h exp 0/0", occ_c, mv_c); else n_pass++;
        n_checks++; if (srdy_c !== 1'b1) $display("FAIL rst_s_ready got %0h exp 1", srdy_c); else n_pass++;
        sv_c = 1'b1; din_c = 8'h51;
        step();
        din_c = 8'h52;
        step();
        sv_c = 1'b0;
        #1;
        n_checks++; if (srdy_c !== 1'b0) $display("FAIL rst_credits_two got %0h exp 0", srdy_c); else n_pass++;
        step();
        step();
        n_checks++; if (occ_c !== 2'd2 || md_c !== 8'h51) $display("FAIL rst_refill got occ=%0d d=%0h exp 2/51", occ_c, md_c); else n_pass++;
        n_checks++; if (err_c !== 1'b0) $display("FAIL rst_refill_err got %0h exp 0", err_c); else n_pass++;
    endtask

    initial begin
        srst = 1'b1;
        sv_a = 1'b1; sv_b = 1'b0; sv_c = 1'b0; sv_d = 1'b0;
        mr_a = 1'b0; mr_b = 1'b0; mr_c = 1'b0; mr_d = 1'b0;
        din_a = 8'h00; din_b = 8'h00; din_c = 8'h00; din_d = 8'h00;
        frc_c = 1'b0; frc_d = 8'h00;
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_wrap();
        test_overflow_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
